// File: rtl/packet_arbiter36_x4.sv
// packet_arbiter36_x4: packet-granular round-robin arbiter sharing one fifo36
// output stream among four fifo36 inputs, with an optional strict-priority port.
// Config word at BASE: [3:0] enable mask, [4] priority enable, [6:5] priority port.
module packet_arbiter36_x4 #(
  parameter logic [7:0] BASE         = 8'd0,
  parameter logic [3:0] DEFAULT_MASK = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [35:0] in0_data,
  input  logic [35:0] in1_data,
  input  logic [35:0] in2_data,
  input  logic [35:0] in3_data,
  input  logic        in0_valid,
  input  logic        in1_valid,
  input  logic        in2_valid,
  input  logic        in3_valid,
  output logic        in0_ready,
  output logic        in1_ready,
  output logic        in2_ready,
  output logic        in3_ready,
  output logic [35:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  active_port,
  output logic        busy
);

  typedef enum logic {
    S_IDLE,
    S_PASS
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  mask_q, mask_d;
  logic        prio_en_q, prio_en_d;
  logic [1:0]  prio_port_q, prio_port_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [1:0]  active_port_q, active_port_d;
  logic        busy_q, busy_d;

  logic [35:0] in_data [4];
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  cand;
  logic        grant_vld;
  logic [1:0]  grant;
  logic        unused_set_data;

  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;
  assign in_data[2] = in2_data;
  assign in_data[3] = in3_data;
  assign in_valid   = {in3_valid, in2_valid, in1_valid, in0_valid};
  assign in0_ready  = in_ready[0];
  assign in1_ready  = in_ready[1];
  assign in2_ready  = in_ready[2];
  assign in3_ready  = in_ready[3];
  assign active_port = active_port_q;
  assign busy        = busy_q;
  assign unused_set_data = ^set_data[31:7];

  // Config register: load on a matching setting-bus write, otherwise hold.
  always_comb begin
    mask_d      = mask_q;
    prio_en_d   = prio_en_q;
    prio_port_d = prio_port_q;
    if (set_stb && (set_addr == BASE)) begin
      mask_d      = set_data[3:0];
      prio_en_d   = set_data[4];
      prio_port_d = set_data[6:5];
    end
  end

  // Config storage; only rst restores defaults, clr leaves config intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q      <= DEFAULT_MASK;
      prio_en_q   <= 1'b0;
      prio_port_q <= 2'd0;
    end else begin
      mask_q      <= mask_d;
      prio_en_q   <= prio_en_d;
      prio_port_q <= prio_port_d;
    end
  end

  // Grant selection: priority port if enabled and eligible, else rotate from last grantee.
  always_comb begin
    logic [1:0] idx;
    cand      = in_valid & mask_q;
    grant_vld = 1'b0;
    grant     = last_grant_q;
    idx       = '0;
    if (prio_en_q && cand[prio_port_q]) begin
      grant_vld = 1'b1;
      grant     = prio_port_q;
    end else begin
      for (int unsigned i = 1; i <= 4; i++) begin
        idx = last_grant_q + 2'(i);
        if (!grant_vld && cand[idx]) begin
          grant_vld = 1'b1;
          grant     = idx;
        end
      end
    end
  end

  // Packet FSM: arbitrate in IDLE, pass the owner's stream through in PASS until EOF.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    active_port_d = active_port_q;
    busy_d        = busy_q;
    out_data      = in_data[active_port_q];
    out_valid     = 1'b0;
    in_ready      = '0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          state_d       = S_PASS;
          active_port_d = grant;
          last_grant_d  = grant;
          busy_d        = 1'b1;
        end
      end
      S_PASS: begin
        out_valid               = in_valid[active_port_q];
        in_ready[active_port_q] = out_ready;
        if (out_valid && out_ready && out_data[33]) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Arbitration state; clr aborts an in-flight packet just like rst.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 2'd3;
      active_port_q <= 2'd0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      active_port_q <= active_port_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: tb/tb_packet_arbiter36_x4.sv
// Directed bench for packet_arbiter36_x4: rotation, priority, stalls,
// single-line packets, mid-packet mask change and clr.
module tb_packet_arbiter36_x4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic        out_ready = 1'b1;
  logic [35:0] out_data;
  logic        out_valid;
  logic [1:0]  active_port;
  logic        busy;
  logic        in0_ready, in1_ready, in2_ready, in3_ready;
  logic [3:0]  rdy;

  logic [3:0]   src_en = 4'h0;
  logic         src_rst = 1'b1;
  int unsigned  src_len [4];
  int unsigned  src_idx [4];
  logic [35:0]  src_data [4];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  packet_arbiter36_x4 #(.BASE(8'd0), .DEFAULT_MASK(4'hF)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .in0_data(src_data[0]), .in1_data(src_data[1]),
    .in2_data(src_data[2]), .in3_data(src_data[3]),
    .in0_valid(src_en[0]), .in1_valid(src_en[1]),
    .in2_valid(src_en[2]), .in3_valid(src_en[3]),
    .in0_ready(in0_ready), .in1_ready(in1_ready),
    .in2_ready(in2_ready), .in3_ready(in3_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .active_port(active_port), .busy(busy)
  );

  assign rdy = {in3_ready, in2_ready, in1_ready, in0_ready};

  // Packet sources: line index advances on each accepted line, wraps after EOF.
  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (src_rst) src_idx[p] <= 0;
      else if (src_en[p] && rdy[p])
        src_idx[p] <= (src_idx[p] == src_len[p] - 1) ? 0 : src_idx[p] + 1;
    end
  end

  always_comb begin
    for (int p = 0; p < 4; p++)
      src_data[p] = {2'(p), src_idx[p] == src_len[p] - 1, src_idx[p] == 0, 16'(p), 16'(src_idx[p])};
  end

  function automatic logic [35:0] exp_line(input int p, input int idx, input int len);
    logic [35:0] v;
    v[35:34] = 2'(p);
    v[33]    = (idx == len - 1);
    v[32]    = (idx == 0);
    v[31:16] = 16'(p);
    v[15:0]  = 16'(idx);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input int exp_port);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_rdy"},   64'(rdy), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_port"},  64'(active_port), 64'(exp_port));
  endtask

  task automatic chk_line(input string tag, input int p, input int idx, input int len);
    logic [3:0] er;
    er    = '0;
    er[p] = out_ready;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"},  64'(out_data), 64'(exp_line(p, idx, len)));
    chk({tag, "_port"},  64'(active_port), 64'(p));
    chk({tag, "_busy"},  64'(busy), 64'd1);
    chk({tag, "_rdy"},   64'(rdy), 64'(er));
  endtask

  initial begin
    logic pat [4];
    int   exp_idx;
    int   t;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int p = 0; p < 4; p++) src_len[p] = 3;

    // Reset state
    repeat (2) tick();
    #4;
    chk_idle("reset", 0);

    // 1: round robin 0,1,2,3,0 with 3-line packets
    tick();
    rst = 1'b0;
    src_rst = 1'b0;
    src_en = 4'hF;
    #4;
    chk_idle("t1_idle0", 0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) begin
        tick(); #4;
        chk_line($sformatf("t1_pkt%0d_l%0d", k, i), k % 4, i, 3);
      end
      tick();
      if (k == 4) src_en = 4'h0;
      #4;
      chk_idle($sformatf("t1_gap%0d", k), k % 4);
    end

    // 2: mask 0 blocks all; then priority port 2 starves port 1
    tick();
    set_stb = 1'b1; set_data = 32'h0000_0050;
    #4; chk_idle("t2_wr0", 0);
    tick();
    set_stb = 1'b0;
    src_len[1] = 2; src_len[2] = 2;
    src_en = 4'b0110;
    #4; chk_idle("t2_masked0", 0);
    for (int i = 1; i < 3; i++) begin
      tick(); #4; chk_idle($sformatf("t2_masked%0d", i), 0);
    end
    tick();
    set_stb = 1'b1; set_data = 32'h0000_005F;
    #4; chk_idle("t2_wr_same_cycle", 0);
    tick();
    set_stb = 1'b0;
    #4; chk_idle("t2_arb", 0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2; i++) begin
        tick(); #4;
        chk_line($sformatf("t2_pkt%0d_l%0d", k, i), 2, i, 2);
      end
      tick();
      if (k == 2) src_en = 4'h0;
      #4;
      chk_idle($sformatf("t2_gap%0d", k), 2);
    end

    // 3: 10-line packet on port 0 with out_ready pattern 1,0,0,1
    tick();
    set_stb = 1'b1; set_data = 32'h0000_000F;
    #4; chk_idle("t3_wr", 2);
    tick();
    set_stb = 1'b0;
    src_len[0] = 10; src_len[1] = 2;
    src_en = 4'b0011;
    #4; chk_idle("t3_arb", 2);
    exp_idx = 0;
    t = 0;
    while (exp_idx < 10 && t < 40) begin
      tick();
      out_ready = pat[t % 4];
      #4;
      chk_line($sformatf("t3_c%0d", t), 0, exp_idx, 10);
      if (out_ready) exp_idx++;
      t++;
    end
    tick();
    out_ready = 1'b1;
    src_en[0] = 1'b0;
    #4; chk_idle("t3_gap", 0);
    for (int i = 0; i < 2; i++) begin
      tick(); #4;
      chk_line($sformatf("t3_p1_l%0d", i), 1, i, 2);
    end
    tick();
    src_en = 4'h0;
    #4; chk_idle("t3_end", 1);

    // 4: single-line packet on port 3
    tick();
    src_len[3] = 1;
    src_en = 4'b1000;
    #4; chk_idle("t4_arb", 1);
    tick(); #4;
    chk_line("t4_line", 3, 0, 1);
    chk("t4_sof_eof", 64'(out_data[33:32]), 64'd3);
    tick();
    src_en = 4'h0;
    #4; chk_idle("t4_after", 3);

    // 5: mask drops port 0 while its packet is in flight
    tick();
    src_len[0] = 4;
    src_en = 4'b0001;
    #4; chk_idle("t5_arb", 3);
    tick(); #4; chk_line("t5_l0", 0, 0, 4);
    tick();
    set_stb = 1'b1; set_data = 32'h0000_000E;
    #4; chk_line("t5_l1", 0, 1, 4);
    tick();
    set_stb = 1'b0;
    #4; chk_line("t5_l2", 0, 2, 4);
    tick(); #4; chk_line("t5_l3", 0, 3, 4);
    for (int i = 0; i < 3; i++) begin
      tick(); #4; chk_idle($sformatf("t5_masked%0d", i), 0);
    end
    tick();
    src_en = 4'h0;
    set_stb = 1'b1; set_data = 32'h0000_000F;
    #4; chk_idle("t5_wr", 0);

    // 6: clr on line 5 of a 9-line packet
    tick();
    set_stb = 1'b0;
    src_len[0] = 9; src_len[1] = 2;
    src_en = 4'b0001;
    #4; chk_idle("t6_arb", 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) src_en = 4'b0011;
      #4;
      chk_line($sformatf("t6_l%0d", i), 0, i, 9);
    end
    tick();
    clr = 1'b1;
    #4; chk_line("t6_l4_clr", 0, 4, 9);
    tick();
    clr = 1'b0;
    src_rst = 1'b1;
    #4; chk_idle("t6_after_clr", 0);
    tick();
    src_rst = 1'b0;
    #4; chk_line("t6_regrant_l0", 0, 0, 9);
    tick(); #4; chk_line("t6_regrant_l1", 0, 1, 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/packet_arbiter36_x4.md
Name: packet_arbiter36_x4

Overview:
- Packet-granular round-robin arbiter that shares one fifo36 output stream (Ethernet/com TX path) among 4 fifo36 input streams, e.g. DSP RX, control responses, CPU TX and external pass-through.
- Never interleaves packets: once granted, an input owns the output until its EOF line transfers.
- An optional strict-priority port can bypass the rotation, for low-latency control replies.
- Configured via the standard setting-register bus.

Parameters:
- BASE, 0, setting-register address of the config word.
- DEFAULT_MASK, 4'hF, per-input enable mask loaded at reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- clr  in  1  synchronous clear of arbitration state only
- set_stb  in  1  setting strobe
- set_addr  in  8  setting address
- set_data  in  32  setting data
- in0_data, in1_data, in2_data, in3_data  in  36  input lines: [31:0] payload, [32] SOF, [33] EOF, [35:34] occupancy
- in0_valid, in1_valid, in2_valid, in3_valid  in  1  input valid
- in0_ready, in1_ready, in2_ready, in3_ready  out  1  input ready
- out_data  out  36  arbitrated output data
- out_valid  out  1  output valid
- out_ready  in  1  output ready
- active_port  out  2  currently or last granted input
- busy  out  1  high while a packet is in flight

Behaviour:
- Config register at BASE (setting_reg semantics, written when set_stb && set_addr==BASE):
  - [3:0] enable mask.
  - [4] priority enable.
  - [6:5] priority port.
  - Reset value: mask=DEFAULT_MASK, prio_en=0, prio_port=0.
- State machine: IDLE, PASS. Reset/clr -> IDLE, last_grant=3 (so port 0 is first in rotation), active_port=0, busy=0.
- Output reset values: out_valid=0, all inN_ready=0.
- IDLE:
  - Candidate set = inN_valid && mask[N].
  - If prio_en and the priority port is a candidate, grant it.
  - Otherwise grant the first candidate scanning last_grant+1, +2, +3, +4 (mod 4). The previous grantee is considered last.
  - On a grant: register active_port; set last_grant=grant (also on priority grants); busy<=1; next state PASS.
  - No candidates: stay in IDLE.
  - No data transfers in IDLE. out_valid=0, all ready=0.
- PASS:
  - out_data = in[active_port]_data (combinational mux).
  - out_valid = in[active_port]_valid.
  - in[active_port]_ready = out_ready; the other readys are 0.
  - On out_valid && out_ready && out_data[33]: go to IDLE, busy<=0.
- Latency and throughput:
  - Zero-cycle combinational data path in PASS.
  - One IDLE arbitration cycle between packets, so the minimum packet pitch is len+1 cycles.
  - Full throughput within a packet.
- Lines are passed verbatim, including the occupancy bits. The SOF bit is not checked; the first line after the grant is the packet start.
- A single-line packet (SOF and EOF both set) transfers in one PASS cycle, then the block returns to IDLE.
- A mask or priority change mid-packet does not abort the packet. The new config applies at the next IDLE decision.
- A priority port whose mask bit is clear is never granted.
- Simultaneous set_stb write and arbitration in the same cycle: the decision uses the old register value.
- rst or clr mid-packet:
  - Returns to IDLE immediately.
  - Deasserts all readys the same cycle the state updates.
  - The partial packet is truncated downstream; cleanup is the responsibility of upstream/downstream clr.
- out_ready low in PASS stalls the granted input only; no line is lost or duplicated.

Test Plan:
1. Reset, all 4 inputs valid with 3-line packets (payload = port<<16 | idx), out_ready=1 -> grants in order 0,1,2,3,0; 4 cycles per packet; each packet contiguous; active_port follows the grants.
2. Write BASE with 32'h0000_0050 (prio_en=1, prio_port=2, mask=0) -> no grants and all readys 0. Then write 32'h0000_005F, keep ports 1 and 2 always valid -> port 2 wins every arbitration and port 1 starves.
3. Port 0 sends a 10-line packet; out_ready toggles 1,0,0,1 repeating -> exactly 10 lines out, in order, with no duplicates; EOF on line 10; port 1 is granted in the next arbitration cycle.
4. Single-line packet (data[33:32]=2'b11) on port 3 -> PASS lasts 1 cycle; IDLE follows; busy pulses for 1 cycle.
5. Mask written to 4'b1110 while port 0 is mid-packet -> port 0 finishes its packet; port 0 is not granted afterwards while its valid stays high.
6. clr asserted on line 5 of a 9-line packet -> next cycle IDLE with readys 0; the next grant goes to port 0 (last_grant=3).
